// File: rtl/rv32_mem_pkg.sv
// Memory-op encodings, arbiter FSM states and the access-alignment rule
// shared by the data-memory arbiter files.
package rv32_mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_e;

  // Unused func3 codes (011/110/111) are rejected like misaligned accesses.
  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] lsb);
    case (op)
      LB, LBU: return 1'b0;
      LH, LHU: return lsb[0];
      LW:      return (lsb != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way grant picker: a lone request wins outright, on contention the
// requester that was not granted last wins.
module dmem_arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: default assignment first so every path drives gnt and no latch is inferred.
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter (CPU + loader/debug) with alignment checking.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module dmem_arbiter
  import rv32_mem_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [2:0]  m0_op,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_op,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemdatain,
  output logic [2:0]  dmemop,
  output logic        dmemwe,
  input  logic [31:0] dmemdataout,
  output logic        busy
);

  state_e      state_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  op_q;
  logic        id_q;
  logic [1:0]  rvalid_q;
  logic [1:0]  err_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        pick_last;
  logic        gnt_id;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_op;
  logic        sel_misaligned;

  // Requests are only considered while idle, so gnt can only rise in IDLE.
  assign req = {m1_req, m0_req} & {2{state_q == IDLE}};

  dmem_arb_pick u_pick (
    .req  (req),
    .last (pick_last),
    .gnt  (gnt)
  );

  assign gnt_id         = gnt[1];
  assign sel_we         = gnt_id ? m1_we    : m0_we;
  assign sel_addr       = gnt_id ? m1_addr  : m0_addr;
  assign sel_wdata      = gnt_id ? m1_wdata : m0_wdata;
  assign sel_op         = gnt_id ? m1_op    : m0_op;
  assign sel_misaligned = op_misaligned(sel_op, sel_addr[1:0]);

`ifdef DMEM_ARB_RR_EN
  // Holds the requester favoured on the next contention; every grant flips it away.
  logic rr_ptr_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)     rr_ptr_q <= 1'b0;
    else if (|gnt)   rr_ptr_q <= ~gnt_id;
  end

  assign pick_last = ~rr_ptr_q;
`else
  assign pick_last = 1'b1;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_q     <= 3'b000;
      id_q     <= 1'b0;
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            if (sel_misaligned) begin
              err_q[gnt_id] <= 1'b1;
            end else begin
              we_q    <= sel_we;
              addr_q  <= sel_addr;
              wdata_q <= sel_wdata;
              op_q    <= sel_op;
              id_q    <= gnt_id;
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: state_q <= we_q ? IDLE : WAIT;
        WAIT: begin
          rvalid_q[id_q] <= 1'b1;
          if (id_q) rdata1_q <= dmemdataout;
          else      rdata0_q <= dmemdataout;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_gnt     = gnt[0];
  assign m1_gnt     = gnt[1];
  assign m0_rvalid  = rvalid_q[0];
  assign m1_rvalid  = rvalid_q[1];
  assign m0_err     = err_q[0];
  assign m1_err     = err_q[1];
  assign m0_rdata   = rdata0_q;
  assign m1_rdata   = rdata1_q;
  assign dmemaddr   = addr_q;
  assign dmemdatain = wdata_q;
  assign dmemop     = op_q;
  assign dmemwe     = (state_q == ACCESS) && we_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed transactions push expected
// rvalid/err responses; a negedge monitor pops and compares them.
module tb_dmem_arbiter;
  import rv32_mem_pkg::*;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [2:0]  m0_op = '0, m1_op = '0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] dmemaddr, dmemdatain, dmemdataout;
  logic [2:0]  dmemop;
  logic        dmemwe, busy;

  dmem_arbiter dut (
    .clock(clock), .resetn(resetn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_op(m0_op),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_op(m1_op),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dmemaddr(dmemaddr), .dmemdatain(dmemdatain), .dmemop(dmemop), .dmemwe(dmemwe),
    .dmemdataout(dmemdataout), .busy(busy)
  );

  always #5 clock = ~clock;

  // Word-addressed memory attached to the arbiter; byte lanes are ignored.
  logic [31:0] mem [0:255];
  logic [31:0] shadow [0:255];
  assign dmemdataout = mem[dmemaddr[9:2]];
  always @(posedge clock) if (dmemwe) mem[dmemaddr[9:2]] <= dmemdatain;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // resp bits: {m1_err, m0_err, m1_rvalid, m0_rvalid}
  typedef struct {
    int          id;
    logic [3:0]  resp;
    int          cyc;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge clock) begin
    logic [3:0] resp;
    exp_t e;
    resp = {m1_err, m0_err, m1_rvalid, m0_rvalid};
    if (resetn && resp != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {28'h0, resp}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("resp_kind", {28'h0, resp}, {28'h0, e.resp});
        check("resp_cycle", e.cyc, cyc);
        if (e.resp[1:0] != 2'b00)
          check("resp_rdata", (e.id == 1) ? m1_rdata : m0_rdata, e.data);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_we"}, {31'h0, dmemwe}, 32'h0);
    check({tag, "_flags"}, {26'h0, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, m1_err, m0_err}, 32'h0);
    check({tag, "_addr"}, dmemaddr, 32'h0);
    check({tag, "_wdata"}, dmemdatain, 32'h0);
    check({tag, "_op"}, {29'h0, dmemop}, 32'h0);
    check({tag, "_rdata0"}, m0_rdata, 32'h0);
    check({tag, "_rdata1"}, m1_rdata, 32'h0);
  endtask

  // Presents one request, waits (bounded) for its grant, registers the expected
  // response and checks the memory-side ACCESS cycle. Returns in the cycle after grant.
  task automatic issue(input int k, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] op, input bit exp_err);
    int n;
    bit got;
    int gc;
    @(posedge clock); #1;
    if (k == 0) begin
      m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_op = op; m0_req = 1'b1;
    end else begin
      m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_op = op; m1_req = 1'b1;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clock);
      n++;
      if ((k == 0) ? m0_gnt : m1_gnt) got = 1'b1;
    end
    check("gnt_seen", {31'h0, got}, 32'h1);
    if (got) begin
      gc = cyc;
      check("gnt_onehot", {30'h0, m1_gnt, m0_gnt}, (k == 0) ? 32'h1 : 32'h2);
      check("gnt_idle", {30'h0, busy, dmemwe}, 32'h0);
      if (exp_err)  exp_q.push_back('{k, (k == 1) ? 4'b1000 : 4'b0100, gc + 1, 32'h0});
      else if (!we) exp_q.push_back('{k, (k == 1) ? 4'b0010 : 4'b0001, gc + 3, shadow[addr[9:2]]});
      else          shadow[addr[9:2]] = wdata;
    end
    @(posedge clock); #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clock);
    if (exp_err) begin
      check("err_no_access", {30'h0, busy, dmemwe}, 32'h0);
    end else begin
      check("acc_busy", {31'h0, busy}, 32'h1);
      check("acc_we", {31'h0, dmemwe}, {31'h0, we});
      check("acc_addr", dmemaddr, addr);
      check("acc_op", {29'h0, dmemop}, {29'h0, op});
      if (we) check("acc_wdata", dmemdatain, wdata);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy && n < 10);
    check("idle_reached", {31'h0, busy}, 32'h0);
  endtask

  typedef struct {
    int          k;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  op;
    bit          err;
  } vec_t;

  vec_t vecs[$] = '{
    '{0, 1'b0, 32'h0000_0102, 32'h0,          LW,     1'b1},
    '{1, 1'b0, 32'h0000_0103, 32'h0,          LH,     1'b1},
    '{0, 1'b0, 32'h0000_0100, 32'h0,          3'b011, 1'b1},
    '{1, 1'b0, 32'h0000_0100, 32'h0,          3'b110, 1'b1},
    '{0, 1'b1, 32'h0000_0100, 32'h1111_1111,  3'b111, 1'b1},
    '{1, 1'b1, 32'h0000_0201, 32'h2222_2222,  SW,     1'b1},
    '{0, 1'b0, 32'h0000_0101, 32'h0,          LHU,    1'b1},
    '{0, 1'b0, 32'h0000_0102, 32'h0,          LHU,    1'b0},
    '{1, 1'b0, 32'h0000_0103, 32'h0,          LBU,    1'b0},
    '{1, 1'b1, 32'h0000_0203, 32'h0000_00A5,  SB,     1'b0},
    '{0, 1'b0, 32'h0000_0200, 32'h0,          LW,     1'b0},
    '{1, 1'b1, 32'h0000_0104, 32'h1234_5678,  SW,     1'b0},
    '{1, 1'b0, 32'h0000_0106, 32'h0,          LH,     1'b0}
  };

  initial begin
    int gids[4];
    int gcy[4];
    int cnt;
    int n;
    exp_t dropped;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0;
      shadow[i] = 32'h0;
    end

    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("rst");
    resetn = 1'b1;

    // m0 word write followed by an m1 read of the same word
    issue(0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, SW, 1'b0);
    wait_idle();
    issue(1, 1'b0, 32'h0000_0100, 32'h0, LW, 1'b0);
    wait_idle();
    repeat (2) @(negedge clock);
    check("rdata1_hold", m1_rdata, 32'hDEAD_BEEF);
    check("rdata0_untouched", m0_rdata, 32'h0);

    foreach (vecs[i]) begin
      issue(vecs[i].k, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].op, vecs[i].err);
      wait_idle();
    end

    // Reset in WAIT aborts the read; its expected response is withdrawn
    issue(0, 1'b0, 32'h0000_0100, 32'h0, LW, 1'b0);
    @(posedge clock); #1;
    check("wait_busy", {31'h0, busy}, 32'h1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("abort");
    dropped = exp_q.pop_back();
    check("abort_dropped_id", dropped.id, 32'h0);
    @(posedge clock); #1;
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    check("abort_idle", {31'h0, busy}, 32'h0);

    // Both requesters hold read requests continuously from a fresh reset
    @(posedge clock); #1;
    m0_we = 1'b0; m0_addr = 32'h0000_0100; m0_op = LW;
    m1_we = 1'b0; m1_addr = 32'h0000_0104; m1_op = LW;
    m0_req = 1'b1;
    m1_req = 1'b1;
    cnt = 0;
    n = 0;
    while (cnt < 4 && n < 40) begin
      @(negedge clock);
      n++;
      if (m0_gnt || m1_gnt) begin
        gids[cnt] = m1_gnt ? 1 : 0;
        gcy[cnt] = cyc;
        exp_q.push_back('{gids[cnt], m1_gnt ? 4'b0010 : 4'b0001, cyc + 3,
                          shadow[m1_gnt ? 8'h41 : 8'h40]});
        cnt++;
      end
    end
    @(posedge clock); #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    check("cont_grants", cnt, 32'd4);
    for (int i = 0; i < cnt; i++) begin
`ifdef DMEM_ARB_RR_EN
      check("cont_id", gids[i], i % 2);
`else
      check("cont_id", gids[i], 32'd0);
`endif
      if (i > 0) check("cont_spacing", gcy[i] - gcy[i-1], 32'd3);
    end
    wait_idle();

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("queue_drained", exp_q.size(), 32'd0);
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have ports: clock  in  1  rising-edge clock for all state.
REQ-002 SHALL have ports: resetn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have per requester k in {0,1} (0 = CPU load/store, 1 = loader/debug): mk_req in 1; mk_we in 1; mk_addr in 32; mk_wdata in 32; mk_op in 3 (func3 memop).
REQ-004 SHALL have per requester k outputs: mk_gnt out 1; mk_rvalid out 1; mk_rdata out 32; mk_err out 1.
REQ-005 SHALL have memory-side ports: dmemaddr out 32; dmemdatain out 32; dmemop out 3; dmemwe out 1; dmemdataout in 32.
REQ-006 SHALL have port busy out 1, high whenever state != IDLE.

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS, WAIT.
REQ-008 In IDLE with at least one mk_req high, SHALL assert exactly one mk_gnt combinationally that cycle, latch that requester's we/addr/wdata/op/id at the edge, and go to ACCESS.
REQ-009 Requesters SHALL hold mk_req and fields stable until mk_gnt; the arbiter SHALL sample them only in the grant cycle.
REQ-010 In ACCESS, SHALL drive dmemaddr/dmemdatain/dmemop from latches, with dmemwe = latched we.
REQ-011 Write: ACCESS -> IDLE; total latency req-to-idle 2 cycles; no rvalid.
REQ-012 Read: ACCESS -> WAIT; at WAIT's end SHALL register dmemdataout into mk_rdata of the latched id and pulse that mk_rvalid for exactly 1 cycle (cycle after WAIT).
REQ-013 The rvalid cycle SHALL coincide with IDLE; a new grant in that same cycle SHALL be legal.
REQ-014 Misalignment SHALL be checked in the grant cycle: op 010 with addr[1:0]!=0, or op 001/101 with addr[0]!=0.
REQ-015 On misalignment SHALL pulse mk_err for 1 cycle (cycle after grant), stay IDLE, and issue no memory access (dmemwe stays 0).
REQ-016 Op encodings 011/110/111 SHALL be treated as misaligned (err).
REQ-017 Outside ACCESS, dmemwe SHALL be 0; dmemaddr/dmemdatain/dmemop SHALL hold last latched values.
REQ-018 mk_rdata SHALL hold its value until the next read completion for that requester.
REQ-019 Simultaneous m0_req and m1_req SHALL be resolved per REQ-023/024; the loser waits with req held, no gnt.

Reset
REQ-020 On resetn low, SHALL immediately enter IDLE and force dmemwe, all mk_gnt/mk_rvalid/mk_err and busy to 0.
REQ-021 On reset, latches, dmemaddr, dmemdatain, mk_rdata SHALL be 0, dmemop 000, and the RR pointer SHALL point to requester 0.
REQ-022 Reset during ACCESS/WAIT SHALL abort the transaction with no rvalid after release.

Configuration
REQ-023 With DMEM_ARB_RR_EN defined, SHALL use round-robin: on contention, grant the requester not granted last; pointer updates on every grant, including err grants.
REQ-024 Without DMEM_ARB_RR_EN, SHALL use fixed priority, m0 over m1, with no pointer register.

Structure
REQ-025 Shared package rv32_mem_pkg SHALL hold the memop constants (LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010) and the FSM state enum.
REQ-026 Grant selection SHALL be a sub-module dmem_arb_pick (req[1:0], last -> gnt[1:0]); the FSM, latches and alignment check stay in dmem_arbiter.

Verification
REQ-027 m0 write addr 0x100, wdata 0xDEADBEEF, op 010 -> m0_gnt cycle 0; dmemwe=1 only in cycle 1 with addr 0x100; busy=1 in cycle 1.
REQ-028 m1 read addr 0x100 op 010 after the REQ-027 write -> m1_rvalid pulses cycle 3 with m1_rdata 0xDEADBEEF; m0_rvalid stays 0.
REQ-029 m0 and m1 both hold req continuously -> with RR_EN, grants alternate 0,1,0,1; without, m0 wins every arbitration and m1 is never granted.
REQ-030 m0 op 010 addr 0x102 -> m0_gnt, m0_err pulse next cycle, dmemwe never 1, busy stays 0.
REQ-031 resetn low during WAIT of a read -> outputs zero immediately; after release, no rvalid and state IDLE.
